// File: rtl/gpio_pkg.sv
// gpio_pkg: shared channel-mode encodings for the PLC digital-output stage.
// Ports: none (package only).
package gpio_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_PULSE  = 2'b01,
        MODE_PWM    = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

endpackage

// File: rtl/gpio_out_chan.sv
// gpio_out_chan: one output channel -- mode/param regs, pulse counter, output select.
// Ports: cfg write (qualified), DO write bit, trip, do_reg bit, PWM timebase in; out/expire out.
module gpio_out_chan
    import gpio_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_cfg_we,
    input  logic [1:0]       i_cfg_mode,
    input  logic [CNT_W-1:0] i_cfg_param,
    input  logic             i_wr,
    input  logic             i_wbit,
    input  logic             i_trip,
    input  logic             i_do_bit,
    input  logic [CNT_W-1:0] i_tb,
    input  logic             i_per_nz,
    output logic             o_out,
    output logic             o_expire
);

    mode_e            r_mode;
    logic [CNT_W-1:0] r_param;
    logic [CNT_W-1:0] r_pcnt;

    logic             w_pulse;
    logic             w_load;
    logic             w_cancel;
    logic             w_mchg;
    logic [CNT_W-1:0] w_pcnt_nxt;

    always_comb begin
        w_pulse  = (r_mode == MODE_PULSE);
        w_load   = w_pulse & i_wr & i_wbit;
        w_cancel = w_pulse & i_wr & ~i_wbit;
        w_mchg   = i_cfg_we & (mode_e'(i_cfg_mode) != r_mode);
    end

    // Mode change and watchdog trip both kill an in-flight pulse.
    always_comb begin
        w_pcnt_nxt = r_pcnt;
        if (w_mchg || i_trip) begin
            w_pcnt_nxt = '0;
        end else if (w_load) begin
            w_pcnt_nxt = r_param;
        end else if (w_cancel) begin
            w_pcnt_nxt = '0;
        end else if (r_pcnt != '0) begin
            w_pcnt_nxt = r_pcnt - CNT_W'(1);
        end
    end

    // Expire tells the top to self-clear this channel's do_reg bit.
    always_comb begin
        o_expire = 1'b0;
        if (w_pulse && !w_mchg) begin
            if (i_trip) begin
                o_expire = (r_pcnt != '0);
            end else if (w_load) begin
                o_expire = (r_param == '0);
            end else if (!w_cancel) begin
                o_expire = (r_pcnt == CNT_W'(1));
            end
        end
    end

    // A pulse is high exactly while its do_reg bit is set.
    always_comb begin
        case (r_mode)
            MODE_PWM: o_out = i_do_bit & i_per_nz & (i_tb < r_param);
            default:  o_out = i_do_bit;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode  <= MODE_STATIC;
            r_param <= '0;
            r_pcnt  <= '0;
        end else begin
            if (i_cfg_we) begin
                r_mode  <= mode_e'(i_cfg_mode);
                r_param <= i_cfg_param;
            end
            r_pcnt <= w_pcnt_nxt;
        end
    end

endmodule

// File: rtl/gpio_output_ctrl.sv
// gpio_output_ctrl: masked-write DO register, per-channel static/pulse/PWM, PWM timebase, watchdog.
// Ports: DO write, cfg write, period write, watchdog controls in; do_state, wdt_trip, gpio_o out.
module gpio_output_ctrl
    import gpio_pkg::*;
#(
    parameter int             NCH      = 8,
    parameter int             CNT_W    = 16,
    parameter int             WDT_CYC  = 1000000,
    parameter logic [NCH-1:0] SAFE_VAL = '0,
    localparam int            CH_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH-1:0]   do_wdata,
    input  logic [NCH-1:0]   do_wmask,
    input  logic             do_we,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [1:0]       cfg_mode,
    input  logic [CNT_W-1:0] cfg_param,
    input  logic             per_we,
    input  logic [CNT_W-1:0] per_wdata,
    input  logic             wdt_en,
    input  logic             wdt_kick,
    input  logic             wdt_clr,
    output logic [NCH-1:0]   do_state,
    output logic             wdt_trip,
    output logic [NCH-1:0]   gpio_o
);

    localparam int            WC_W   = $clog2(WDT_CYC);
    localparam logic [WC_W-1:0] WC_RLD = WC_W'(WDT_CYC - 1);

    logic [NCH-1:0]   r_do;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_tb;
    logic [WC_W-1:0]  r_wcnt;
    logic             r_trip;
    logic [NCH-1:0]   r_gpio;

    logic             w_wr;
    logic             w_per_nz;
    logic [NCH-1:0]   w_out;
    logic [NCH-1:0]   w_expire;
    logic [NCH-1:0]   w_do_nxt;
    logic [CNT_W-1:0] w_tb_nxt;
    logic [WC_W-1:0]  w_wcnt_nxt;
    logic             w_trip_nxt;

    assign w_wr     = do_we & ~r_trip;
    assign w_per_nz = (r_period != '0);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        gpio_out_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_cfg_we    (cfg_we && (cfg_ch == CH_W'(i))),
            .i_cfg_mode  (cfg_mode),
            .i_cfg_param (cfg_param),
            .i_wr        (w_wr & do_wmask[i]),
            .i_wbit      (do_wdata[i]),
            .i_trip      (r_trip),
            .i_do_bit    (r_do[i]),
            .i_tb        (r_tb),
            .i_per_nz    (w_per_nz),
            .o_out       (w_out[i]),
            .o_expire    (w_expire[i])
        );
    end

    // Expiry wins over a same-cycle write so param=0 pulses never latch.
    always_comb begin
        w_do_nxt = r_do;
        if (w_wr) begin
            w_do_nxt = (r_do & ~do_wmask) | (do_wdata & do_wmask);
        end
        w_do_nxt = w_do_nxt & ~w_expire;
    end

    // Compare with >= so shrinking the period never strands tb past the end.
    always_comb begin
        w_tb_nxt = r_tb + CNT_W'(1);
        if (per_we || !w_per_nz) begin
            w_tb_nxt = '0;
        end else if (r_tb >= r_period - CNT_W'(1)) begin
            w_tb_nxt = '0;
        end
    end

    always_comb begin
        w_wcnt_nxt = r_wcnt;
        w_trip_nxt = r_trip;
        if (wdt_clr) begin
            w_trip_nxt = 1'b0;
            w_wcnt_nxt = WC_RLD;
        end else begin
            if (do_we || wdt_kick || !wdt_en) begin
                w_wcnt_nxt = WC_RLD;
            end else if (r_wcnt != '0) begin
                w_wcnt_nxt = r_wcnt - WC_W'(1);
            end
            if (wdt_en && (r_wcnt == '0)) begin
                w_trip_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_do     <= '0;
            r_period <= '0;
            r_tb     <= '0;
            r_wcnt   <= WC_RLD;
            r_trip   <= 1'b0;
            r_gpio   <= SAFE_VAL;
        end else begin
            r_do   <= w_do_nxt;
            r_tb   <= w_tb_nxt;
            r_wcnt <= w_wcnt_nxt;
            r_trip <= w_trip_nxt;
            r_gpio <= w_trip_nxt ? SAFE_VAL : w_out;
            if (per_we) begin
                r_period <= per_wdata;
            end
        end
    end

    assign do_state = r_do;
    assign wdt_trip = r_trip;
    assign gpio_o   = r_gpio;

endmodule

// File: tb/tb_gpio_output_ctrl.sv
// tb_gpio_output_ctrl: scoreboard bench for gpio_output_ctrl (NCH=8, WDT_CYC=16, SAFE=A5).
// Ports: none (top-level bench).
module tb_gpio_output_ctrl;

    localparam int NCH   = 8;
    localparam int CNT_W = 16;
    localparam logic [7:0] SAFE = 8'hA5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NCH-1:0]   do_wdata = '0;
    logic [NCH-1:0]   do_wmask = '0;
    logic             do_we = 1'b0;
    logic             cfg_we = 1'b0;
    logic [2:0]       cfg_ch = '0;
    logic [1:0]       cfg_mode = '0;
    logic [CNT_W-1:0] cfg_param = '0;
    logic             per_we = 1'b0;
    logic [CNT_W-1:0] per_wdata = '0;
    logic             wdt_en = 1'b0;
    logic             wdt_kick = 1'b0;
    logic             wdt_clr = 1'b0;
    logic [NCH-1:0]   do_state;
    logic             wdt_trip;
    logic [NCH-1:0]   gpio_o;

    int n_chk = 0;
    int n_fail = 0;

    string       q_tag[$];
    logic [31:0] q_exp[$];

    gpio_output_ctrl #(
        .NCH      (NCH),
        .CNT_W    (CNT_W),
        .WDT_CYC  (16),
        .SAFE_VAL (SAFE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .do_wdata  (do_wdata),
        .do_wmask  (do_wmask),
        .do_we     (do_we),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_mode  (cfg_mode),
        .cfg_param (cfg_param),
        .per_we    (per_we),
        .per_wdata (per_wdata),
        .wdt_en    (wdt_en),
        .wdt_kick  (wdt_kick),
        .wdt_clr   (wdt_clr),
        .do_state  (do_state),
        .wdt_trip  (wdt_trip),
        .gpio_o    (gpio_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] v);
        q_tag.push_back(tag);
        q_exp.push_back(v);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        if (q_exp.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            chk(q_tag.pop_front(), obs, q_exp.pop_front());
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_wr(input logic [7:0] d, input logic [7:0] m);
        do_wdata = d;
        do_wmask = m;
        do_we    = 1'b1;
        step(1);
        do_we    = 1'b0;
    endtask

    task automatic cfg_wr(input int ch, input logic [1:0] md,
                          input logic [CNT_W-1:0] p);
        cfg_ch    = 3'(ch);
        cfg_mode  = md;
        cfg_param = p;
        cfg_we    = 1'b1;
        step(1);
        cfg_we    = 1'b0;
    endtask

    initial begin
        // reset state
        #12;
        sb_push("rst_gpio", 32'(SAFE));
        sb_pop(32'(gpio_o));
        sb_push("rst_state", 32'h0);
        sb_pop(32'(do_state));
        sb_push("rst_trip", 32'h0);
        sb_pop(32'(wdt_trip));
        @(negedge clk);
        rst_n = 1'b1;
        step(1);

        // masked write
        do_wr(8'h0F, 8'hFF);
        do_wr(8'hF0, 8'h3C);
        sb_push("mask_state", 32'h33);
        sb_pop(32'(do_state));
        sb_push("mask_lat", 32'h0F);
        sb_pop(32'(gpio_o));
        step(1);
        sb_push("mask_gpio", 32'h33);
        sb_pop(32'(gpio_o));

        // pulse ch2 len 5
        do_wr(8'h00, 8'hFF);
        cfg_wr(2, 2'b01, 16'd5);
        step(1);
        do_wr(8'h04, 8'h04);
        sb_push("pls_c0", 32'h0);
        sb_pop(32'(gpio_o[2]));
        for (int c = 1; c <= 7; c++) begin
            step(1);
            sb_push($sformatf("pls_c%0d", c), 32'(c <= 5));
            sb_pop(32'(gpio_o[2]));
        end
        sb_push("pls_clr", 32'h0);
        sb_pop(32'(do_state[2]));

        // pulse cancel by write 0
        do_wr(8'h04, 8'h04);
        step(1);
        do_wr(8'h00, 8'h04);
        sb_push("pls_cancel", 32'h0);
        sb_pop(32'(do_state[2]));
        step(1);
        sb_push("pls_cancel_o", 32'h0);
        sb_pop(32'(gpio_o[2]));
        step(6);

        // pulse param 0
        cfg_wr(2, 2'b01, 16'd0);
        do_wr(8'h04, 8'h04);
        sb_push("pls_p0", 32'h0);
        sb_pop(32'(do_state[2]));
        step(1);
        sb_push("pls_p0_o", 32'h0);
        sb_pop(32'(gpio_o[2]));

        // PWM period 10, ch0 duty 3
        per_wdata = 16'd10;
        per_we = 1'b1;
        step(1);
        per_we = 1'b0;
        cfg_wr(0, 2'b10, 16'd3);
        do_wr(8'h01, 8'h01);
        per_we = 1'b1;
        step(1);
        per_we = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            sb_push($sformatf("pwm3_c%0d", c), 32'(((c - 1) % 10) < 3));
            step(1);
            sb_pop(32'(gpio_o[0]));
        end
        cfg_wr(0, 2'b10, 16'd12);
        step(1);
        for (int c = 0; c < 12; c++) begin
            sb_push($sformatf("pwm12_c%0d", c), 32'h1);
            step(1);
            sb_pop(32'(gpio_o[0]));
        end
        per_wdata = 16'd0;
        per_we = 1'b1;
        step(1);
        per_we = 1'b0;
        step(1);
        sb_push("pwm_per0", 32'h0);
        sb_pop(32'(gpio_o[0]));

        // collision: cfg ch1 pulse with same-cycle DO write
        do_wr(8'h00, 8'hFF);
        cfg_ch    = 3'd1;
        cfg_mode  = 2'b01;
        cfg_param = 16'd4;
        cfg_we    = 1'b1;
        do_wr(8'h02, 8'h02);
        cfg_we    = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            step(1);
            sb_push($sformatf("coll_c%0d", c), 32'h1);
            sb_pop(32'(gpio_o[1]));
        end

        // watchdog trip at clk 16
        wdt_en = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            step(1);
            if (c == 15) begin
                sb_push("wdt_c15", 32'h0);
                sb_pop(32'(wdt_trip));
            end
        end
        sb_push("wdt_c16", 32'h1);
        sb_pop(32'(wdt_trip));
        sb_push("wdt_safe", 32'(SAFE));
        sb_pop(32'(gpio_o));
        do_wr(8'hFF, 8'hFF);
        sb_push("wdt_ign", 32'h02);
        sb_pop(32'(do_state));
        wdt_clr = 1'b1;
        step(1);
        wdt_clr = 1'b0;
        sb_push("wdt_clr", 32'h0);
        sb_pop(32'(wdt_trip));
        sb_push("wdt_clr_o", 32'h02);
        sb_pop(32'(gpio_o));

        // clear wins over trip in the same clock
        step(15);
        wdt_clr = 1'b1;
        step(1);
        wdt_clr = 1'b0;
        wdt_en = 1'b0;
        sb_push("wdt_clr_win", 32'h0);
        sb_pop(32'(wdt_trip));
        step(2);

        // asynchronous reset mid-run
        #3;
        rst_n = 1'b0;
        #1;
        sb_push("arst_gpio", 32'(SAFE));
        sb_pop(32'(gpio_o));
        sb_push("arst_state", 32'h0);
        sb_pop(32'(do_state));
        @(negedge clk);
        rst_n = 1'b1;
        step(2);

        if (q_exp.size() != 0) begin
            chk("sb_left", 32'(q_exp.size()), 32'd0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
